// File: rtl/rom_bus_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : rom_bus_arbiter_if
// Description : Bundles the requester handshake and the multiplexed cartridge
//               ROM bus used by rom_bus_arbiter.
//                 req_in        [1:0]  read request per requester
//                 req0_addr_in  [15:0] requester 0 byte address
//                 req1_addr_in  [15:0] requester 1 byte address
//                 ack_out       [1:0]  request accepted (1-cycle pulse)
//                 rvalid_out    [1:0]  read data valid (1-cycle pulse)
//                 rdata_out     [7:0]  read data
//                 busy_out             arbiter not idle
//                 rom_addr_out  [7:0]  multiplexed ROM address byte
//                 rom_latch_out        ROM low-byte address latch strobe
//                 rom_data_in   [7:0]  ROM data bus
//               slave  : the arbiter side.
//               master : the requesters plus the ROM device.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface rom_bus_arbiter_if;
  logic [1:0]  req_in;
  logic [15:0] req0_addr_in;
  logic [15:0] req1_addr_in;
  logic [1:0]  ack_out;
  logic [1:0]  rvalid_out;
  logic [7:0]  rdata_out;
  logic        busy_out;
  logic [7:0]  rom_addr_out;
  logic        rom_latch_out;
  logic [7:0]  rom_data_in;

  modport slave (
    input  req_in, req0_addr_in, req1_addr_in, rom_data_in,
    output ack_out, rvalid_out, rdata_out, busy_out, rom_addr_out, rom_latch_out
  );

  modport master (
    output req_in, req0_addr_in, req1_addr_in, rom_data_in,
    input  ack_out, rvalid_out, rdata_out, busy_out, rom_addr_out, rom_latch_out
  );
endinterface
`default_nettype wire

// File: rtl/rom_bus_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : rom_bus_arbiter
// Description : Shares the cartridge ROM's multiplexed 8-bit address/data bus
//               between two requesters (0 = boot copier, 1 = CPU fetch).
//               Each 16-bit read drives the low address byte, pulses the ROM
//               latch, drives the high byte, then samples the ROM data.
//               Round-robin arbitration, one read in flight at a time.
// Ports       : clk_in  - system clock
//               rst_in  - synchronous reset, active-high
//               bus     - rom_bus_arbiter_if.slave (requesters + ROM bus)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module rom_bus_arbiter #(
  parameter int PERIOD_NS = 10,
  parameter int SETUP_NS  = 50,
  parameter int HOLD_NS   = 5,
  parameter int DATA_NS   = 250
) (
  input  logic              clk_in,
  input  logic              rst_in,
  rom_bus_arbiter_if.slave  bus
);

  // Phase lengths in clock cycles, rounded up, at least one cycle each.
  localparam int C_S_RAW = (SETUP_NS + PERIOD_NS - 1) / PERIOD_NS;
  localparam int C_H_RAW = (HOLD_NS  + PERIOD_NS - 1) / PERIOD_NS;
  localparam int C_D_RAW = (DATA_NS  + PERIOD_NS - 1) / PERIOD_NS;
  localparam int C_S     = (C_S_RAW < 1) ? 1 : C_S_RAW;
  localparam int C_H     = (C_H_RAW < 1) ? 1 : C_H_RAW;
  localparam int C_D     = (C_D_RAW < 1) ? 1 : C_D_RAW;
  localparam int C_SH    = (C_S > C_H) ? C_S : C_H;
  localparam int C_MAX   = (C_SH > C_D) ? C_SH : C_D;
  localparam int C_CW    = $clog2(C_MAX + 1);

  // SETUP is entered in the ack cycle, so it lasts the ack cycle plus S
  // further cycles of stable low byte before the latch rises.
  localparam logic [C_CW-1:0] C_S_END = C_CW'(C_S);
  localparam logic [C_CW-1:0] C_H_END = C_CW'(C_H - 1);
  localparam logic [C_CW-1:0] C_D_END = C_CW'(C_D - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_LATCH = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t          r_state;
  logic [C_CW-1:0] r_cnt;
  logic [7:0]      r_addr_hi;
  logic            r_gsel;
  logic            r_rr;
  logic [1:0]      r_ack;
  logic [1:0]      r_rvalid;
  logic [7:0]      r_rdata;
  logic            r_busy;
  logic [7:0]      r_rom_addr;
  logic            r_latch;

  state_t          w_state;
  logic [C_CW-1:0] w_cnt;
  logic [7:0]      w_addr_hi;
  logic            w_gsel;
  logic            w_rr;
  logic [1:0]      w_ack;
  logic [1:0]      w_rvalid;
  logic [7:0]      w_rdata;
  logic            w_busy;
  logic [7:0]      w_rom_addr;
  logic            w_latch;

  logic            w_gnt;
  logic            w_rr_upd;
  logic [15:0]     w_gnt_addr;
  logic            w_start;

  // Arbitration: a lone requester wins outright; on contention the pointer
  // picks the winner and then flips to favour the other side.
  always_comb begin
    w_gnt    = 1'b0;
    w_rr_upd = r_rr;
    if (bus.req_in == 2'b11) begin
      w_gnt    = r_rr;
      w_rr_upd = ~r_rr;
    end else if (bus.req_in[1]) begin
      w_gnt    = 1'b1;
    end
    w_gnt_addr = w_gnt ? bus.req1_addr_in : bus.req0_addr_in;
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state    = r_state;
    w_cnt      = (r_state == ST_IDLE) ? r_cnt : (r_cnt + C_CW'(1));
    w_addr_hi  = r_addr_hi;
    w_gsel     = r_gsel;
    w_rr       = r_rr;
    w_ack      = 2'b00;
    w_rvalid   = 2'b00;
    w_rdata    = r_rdata;
    w_rom_addr = r_rom_addr;
    w_latch    = r_latch;
    w_start    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_start = |bus.req_in;
      end
      ST_SETUP: begin
        if (r_cnt == C_S_END) begin
          w_state = ST_LATCH;
          w_latch = 1'b1;
        end
      end
      ST_LATCH: begin
        if (r_cnt == C_H_END) begin
          // Latch falls on the same edge the high byte appears, so the
          // latch never sees the high byte.
          w_state    = ST_WAIT;
          w_latch    = 1'b0;
          w_rom_addr = r_addr_hi;
        end
      end
      ST_WAIT: begin
        if (r_cnt == C_D_END) begin
          w_rdata          = bus.rom_data_in;
          w_rvalid[r_gsel] = 1'b1;
          w_state          = ST_IDLE;
          // The cycle carrying rvalid is an idle cycle that may already
          // hold the next grant.
          w_start          = |bus.req_in;
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    if (w_start) begin
      w_ack[w_gnt] = 1'b1;
      w_addr_hi    = w_gnt_addr[15:8];
      w_gsel       = w_gnt;
      w_rr         = w_rr_upd;
      w_rom_addr   = w_gnt_addr[7:0];
      w_state      = ST_SETUP;
    end

    if (w_state != r_state) begin
      w_cnt = '0;
    end

    w_busy = (w_state != ST_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr_hi  <= 8'h00;
      r_gsel     <= 1'b0;
      r_rr       <= 1'b0;
      r_ack      <= 2'b00;
      r_rvalid   <= 2'b00;
      r_rdata    <= 8'h00;
      r_busy     <= 1'b0;
      r_rom_addr <= 8'h00;
      r_latch    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_addr_hi  <= w_addr_hi;
      r_gsel     <= w_gsel;
      r_rr       <= w_rr;
      r_ack      <= w_ack;
      r_rvalid   <= w_rvalid;
      r_rdata    <= w_rdata;
      r_busy     <= w_busy;
      r_rom_addr <= w_rom_addr;
      r_latch    <= w_latch;
    end
  end

  assign bus.ack_out       = r_ack;
  assign bus.rvalid_out    = r_rvalid;
  assign bus.rdata_out     = r_rdata;
  assign bus.busy_out      = r_busy;
  assign bus.rom_addr_out  = r_rom_addr;
  assign bus.rom_latch_out = r_latch;

endmodule
`default_nettype wire
